// File: rtl/proc_pkg.sv
// proc_pkg: shared constants, step encodings and IR field positions for the 9-bit processor
package proc_pkg;
  localparam int WIDTH = 9;
  localparam int NREG = 8;
  localparam logic [2:0] OP_MV = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int X_HI = 5;
  localparam int X_LO = 3;
  localparam int Y_HI = 2;
  localparam int Y_LO = 0;
  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;
endpackage

// File: rtl/proc_control_fsm_if.sv
// proc_control_fsm_if: run/instruction inputs and bus-select/load-enable outputs of the control unit
interface proc_control_fsm_if;
  import proc_pkg::*;
  logic run;
  logic [WIDTH-1:0] din;
  logic [NREG-1:0] rin;
  logic [NREG-1:0] srout;
  logic ain;
  logic gload;
  logic addsub;
  logic sgout;
  logic sdout;
  logic done;
  modport master(input run, din, output rin, srout, ain, gload, addsub, sgout, sdout, done);
  modport slave(output run, din, input rin, srout, ain, gload, addsub, sgout, sdout, done);
endinterface

// File: rtl/proc_control_fsm_dec3to8.sv
// dec3to8: 3-bit index to 8-bit one-hot decoder
module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] y
);
  assign y = 8'd1 << sel;
endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multicycle control unit; fetches an instruction on run and sequences 1-3 execute steps
module proc_control_fsm
  import proc_pkg::*;
(
  input logic clk,
  input logic rst,
  proc_control_fsm_if.master bus
);
  step_t step, step_nx;
  logic [WIDTH-1:0] ir;
  logic [2:0] op;
  logic [NREG-1:0] x_hot, y_hot;
  assign op = ir[OP_HI:OP_LO];
  dec3to8 u_dec_x (.sel(ir[X_HI:X_LO]), .y(x_hot));
  dec3to8 u_dec_y (.sel(ir[Y_HI:Y_LO]), .y(y_hot));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step <= T0;
      ir <= '0;
    end else begin
      step <= step_nx;
      if (step == T0 && bus.run) ir <= bus.din;
    end
  end
  always_comb begin
    step_nx = step;
    bus.rin = '0;
    bus.srout = '0;
    bus.ain = 1'b0;
    bus.gload = 1'b0;
    bus.addsub = 1'b0;
    bus.sgout = 1'b0;
    bus.sdout = 1'b0;
    bus.done = 1'b0;
    case (step)
      T0: step_nx = bus.run ? T1 : T0;
      T1: begin
        step_nx = T0;
        case (op)
          OP_MV: begin
            bus.srout = y_hot;
            bus.rin = x_hot;
            bus.done = 1'b1;
          end
          OP_MVI: begin
            bus.sdout = 1'b1;
            bus.rin = x_hot;
            bus.done = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus.srout = x_hot;
            bus.ain = 1'b1;
            step_nx = T2;
          end
          default: bus.done = 1'b1;
        endcase
      end
      T2: begin
        bus.srout = y_hot;
        bus.gload = 1'b1;
        bus.addsub = op == OP_SUB;
        step_nx = T3;
      end
      default: begin
        bus.sgout = 1'b1;
        bus.rin = x_hot;
        bus.done = 1'b1;
        step_nx = T0;
      end
    endcase
  end
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: directed vectors with hand-computed expected control outputs
module tb_proc_control_fsm;
  import proc_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  localparam logic [21:0] Z = 22'd0;
  always #5 clk = ~clk;
  proc_control_fsm_if bus ();
  proc_control_fsm dut (.clk(clk), .rst(rst), .bus(bus));
  wire [21:0] obs = {bus.rin, bus.ain, bus.gload, bus.addsub, bus.srout, bus.sgout, bus.sdout, bus.done};
  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [21:0] ov(input logic [7:0] rin, input logic [7:0] srout, input logic ain,
                                     input logic gload, input logic addsub, input logic sgout,
                                     input logic sdout, input logic done);
    return {rin, ain, gload, addsub, srout, sgout, sdout, done};
  endfunction
  task automatic cyc(input string tag, input logic [21:0] exp);
    @(posedge clk);
    #1;
    check(tag, obs, exp);
  endtask
  always @(negedge clk)
    check("bus_excl", 22'($countones({bus.srout, bus.sgout, bus.sdout}) <= 1), 22'd1);
  initial begin
    rst = 1'b1;
    bus.run = 1'b1;
    bus.din = 9'h1FF;
    #1;
    check("rst_async", obs, Z);
    for (int i = 0; i < 3; i++) cyc("rst_hold", Z);
    rst = 1'b0;
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) cyc("idle", Z);
    bus.din = 9'b001_010_000;
    bus.run = 1'b1;
    cyc("mvi_t1", ov(8'h04, 8'h00, 0, 0, 0, 0, 1, 1));
    bus.run = 1'b0;
    cyc("mvi_after", Z);
    bus.din = 9'b000_101_010;
    bus.run = 1'b1;
    cyc("mv_t1", ov(8'h20, 8'h04, 0, 0, 0, 0, 0, 1));
    bus.din = 9'h1FF;
    bus.run = 1'b0;
    cyc("mv_after", Z);
    bus.din = 9'b010_001_011;
    bus.run = 1'b1;
    cyc("add_t1", ov(8'h00, 8'h02, 1, 0, 0, 0, 0, 0));
    bus.run = 1'b0;
    cyc("add_t2", ov(8'h00, 8'h08, 0, 1, 0, 0, 0, 0));
    cyc("add_t3", ov(8'h02, 8'h00, 0, 0, 0, 1, 0, 1));
    cyc("add_after", Z);
    bus.din = 9'b011_001_011;
    bus.run = 1'b1;
    cyc("sub_t1", ov(8'h00, 8'h02, 1, 0, 0, 0, 0, 0));
    bus.din = 9'h1FF;
    cyc("sub_t2", ov(8'h00, 8'h08, 0, 1, 1, 0, 0, 0));
    cyc("sub_t3", ov(8'h02, 8'h00, 0, 0, 0, 1, 0, 1));
    bus.run = 1'b0;
    cyc("sub_after", Z);
    bus.din = 9'b010_001_011;
    bus.run = 1'b1;
    cyc("rst_add_t1", ov(8'h00, 8'h02, 1, 0, 0, 0, 0, 0));
    bus.run = 1'b0;
    cyc("rst_add_t2", ov(8'h00, 8'h08, 0, 1, 0, 0, 0, 0));
    rst = 1'b1;
    #1;
    check("rst_mid", obs, Z);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_hold", obs, Z);
    cyc("rst_mid_idle", Z);
    bus.din = 9'b001_111_000;
    bus.run = 1'b1;
    cyc("post_rst_mvi", ov(8'h80, 8'h00, 0, 0, 0, 0, 1, 1));
    bus.run = 1'b0;
    cyc("post_rst_after", Z);
    bus.din = 9'b001_011_000;
    bus.run = 1'b1;
    cyc("b2b_c1_mvi", ov(8'h08, 8'h00, 0, 0, 0, 0, 1, 1));
    bus.din = 9'b010_110_111;
    cyc("b2b_c2_t0", Z);
    cyc("b2b_c3_add", ov(8'h00, 8'h40, 1, 0, 0, 0, 0, 0));
    bus.din = 9'b110_101_011;
    cyc("b2b_c4_add", ov(8'h00, 8'h80, 0, 1, 0, 0, 0, 0));
    cyc("b2b_c5_add", ov(8'h40, 8'h00, 0, 0, 0, 1, 0, 1));
    cyc("b2b_c6_t0", Z);
    cyc("b2b_c7_rsv", ov(8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
    bus.run = 1'b0;
    cyc("b2b_c8_idle", Z);
    cyc("final_idle", Z);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Multicycle control unit of the simple 9-bit processor. It is the driving end of the shared bus.
- Each cycle it generates the bus-source selects (SRout one-hot, SGout, SDout), the register load enables, and the ALU controls; the bus multiplexer consumes the selects.
- Fetches one 9-bit instruction word from Din, sequences it over 1–3 execute steps, and pulses Done on the final step.

Parameters:
- WIDTH, 9, instruction/data word width. Fixed by the IR format III XXX YYY.
- NREG, 8, number of general registers. Fixes the width of Rin and SRout.

Ports:
- Clock  input  1  system clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- Run  input  1  start request; sampled only in step T0.
- Din  input  9  instruction word in T0; immediate operand is presented on the bus in T1 of mvi.
- Rin  output  8  one-hot load enable for R0..R7.
- Ain  output  1  load enable for ALU operand register A.
- Gload  output  1  load enable for ALU result register G.
- AddSub  output  1  ALU op: 0 = add, 1 = subtract.
- SRout  output  8  one-hot bus select R0..R7; 8'h00 when no register drives the bus.
- SGout  output  1  bus select for G.
- SDout  output  1  bus select for Din.
- Done  output  1  instruction-complete strobe, one cycle.

Behaviour:
- State: step counter T0..T3 (2-bit) plus an internal 9-bit IR.
  - IR[8:6] = opcode, IR[5:3] = X, IR[2:0] = Y.
- Reset (async, active-high):
  - step = T0, IR = 9'h000.
  - Every output is 0 while Reset is high and in the first T0 after release.
- All outputs are combinational from (step, IR). IR and step are the only flops.
- T0:
  - Run = 0: stay in T0, all outputs 0.
  - Run = 1: on the clock edge, IR <= Din and step -> T1. No bus select is asserted in T0.
- Opcodes:
  - 000 mv Rx,Ry. T1: SRout = onehot(Y), Rin = onehot(X), Done = 1 -> T0.
  - 001 mvi Rx,#D. T1: SDout = 1, Rin = onehot(X), Done = 1 -> T0.
  - 010 add Rx,Ry.
    - T1: SRout = onehot(X), Ain = 1 -> T2.
    - T2: SRout = onehot(Y), Gload = 1, AddSub = 0 -> T3.
    - T3: SGout = 1, Rin = onehot(X), Done = 1 -> T0.
  - 011 sub Rx,Ry: as add, but AddSub = 1 in T2.
  - 100–111 (reserved): T1: Done = 1 only, no loads, no selects -> T0.
- Bus exclusivity: in every cycle at most one of {SGout, SDout, any SRout bit} is non-zero. SRout is always one-hot or zero.
- mv Rx,Rx (X = Y) is legal; both Rin and SRout carry the same bit.
- Run is ignored in T1..T3. Din changes after T0 do not affect IR.
  - Back-to-back issue: with Run held high, the cycle after Done is T0 and fetches the next word. Issue rate is therefore 2 cycles for mv/mvi and 4 cycles for add/sub.
- Reset asserted mid-instruction: step -> T0 and IR -> 0 immediately. All enables drop in the same cycle. No partial register write may occur after Reset rises.
- Done is high for exactly one cycle per fetched instruction.

Decomposition:
- Shared package proc_pkg holds:
  - Opcode constants OP_MV = 3'b000, OP_MVI = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011.
  - Step encodings T0..T3.
  - Field positions of IR.
- One sub-module: dec3to8, a 3-bit to 8-bit one-hot decoder. It is instantiated twice, for X and Y, and feeds Rin and SRout.

Test Plan:
- Reset held high with Run = 1 and Din = 9'h1FF -> all outputs 0, step stays T0. After release with Run = 0, outputs remain 0 for 5 cycles.
- mvi R2: Din = 9'b001_010_000, Run = 1 for one cycle -> next cycle SDout = 1, Rin = 8'h04, Done = 1, SRout = 0. The following cycle all outputs are 0.
- mv R5,R2: Din = 9'b000_101_010 -> T1 gives SRout = 8'h04, Rin = 8'h20, Done = 1. Din changed to 9'h1FF during T1 has no effect.
- add R1,R3: Din = 9'b010_001_011.
  - T1: SRout = 8'h02, Ain = 1.
  - T2: SRout = 8'h08, Gload = 1, AddSub = 0.
  - T3: SGout = 1, Rin = 8'h02, Done = 1.
  - Repeat with opcode 011 -> identical, except AddSub = 1 in T2.
- Reset pulsed during T2 of add -> Gload, SRout and all other outputs 0 in the same cycle. The next Run fetches and executes mvi correctly.
- Run held high continuously over mvi, add, reserved 110 -> Done pulses at cycles 1, 5 and 7 after the first fetch.
  - Reserved opcode asserts no Rin/select.
  - Bus-exclusivity assertion holds every cycle.
